che_bilinear_itp: RTL and testbench

CHE_BILINEAR_ITP -- requirements
Module: che_bilinear_itp

---
 rtl/che_bilinear_itp_pkg.sv | 33 +++
 rtl/che_itp_fifo.sv | 55 +++++
 rtl/che_bilinear_itp.sv | 115 +++++++++++
 tb/tb_che_bilinear_itp.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/che_bilinear_itp_pkg.sv
// rtl/che_bilinear_itp_pkg.sv - shared widths, constants and descriptor type for the bilinear interpolator
`ifndef CHE_ITP_DEFS
`define CHE_ITP_DEFS
`define DAT_PIX_WD   8
`define WGT_WD       7
`define WGT_ONE      64
`define ITP_SHF      12
`define ITP_FIFO_DEP 4
`endif

package che_bilinear_itp_pkg;
  localparam int DAT_W = `DAT_PIX_WD;
  localparam int WGT_W = `WGT_WD;
  localparam int ROW_W = DAT_W + 7;
  localparam int SUM_W = ROW_W + 7;
  localparam int DSC_W = 2 * WGT_W + 4;

  // Mask bit positions, matching {ul,ur,bl,br}.
  localparam int UL_B = 3;
  localparam int UR_B = 2;
  localparam int BL_B = 1;
  localparam int BR_B = 0;

  typedef struct packed {
    logic [WGT_W-1:0] wx;
    logic [WGT_W-1:0] wy;
    logic [3:0]       msk;
  } dsc_t;

  function automatic logic [WGT_W-1:0] clamp_wgt(input logic [WGT_W-1:0] w);
    return (w > WGT_W'(`WGT_ONE)) ? WGT_W'(`WGT_ONE) : w;
  endfunction
endpackage

// File: rtl/che_itp_fifo.sv
// rtl/che_itp_fifo.sv - small FIFO with full/empty and a sticky overflow flag
module che_itp_fifo
  import che_bilinear_itp_pkg::*;
#(
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid_i,
  input  logic [WD-1:0] s_tdata_i,
  input  logic          m_tready_i,
  output logic [WD-1:0] m_tdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);
  localparam int DEP = `ITP_FIFO_DEP;
  localparam int AW  = $clog2(DEP);

  logic [WD-1:0] mem_q [DEP];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          push, pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEP));
  assign pop       = m_tready_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push      = s_tvalid_i & (~full_o | pop);
  assign m_tdata_o = mem_q[rd_q];
  assign ovf_o     = ovf_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_tdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (s_tvalid_i & ~push) ovf_q <= 1'b1;
    end
  end
endmodule

// File: rtl/che_bilinear_itp.sv
// rtl/che_bilinear_itp.sv - joins four mapped corners with a pixel descriptor and bilinearly interpolates
module che_bilinear_itp
  import che_bilinear_itp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ul_vld_i,
  input  logic                   ur_vld_i,
  input  logic                   bl_vld_i,
  input  logic                   br_vld_i,
  input  logic [`DAT_PIX_WD-1:0] ul_dat_i,
  input  logic [`DAT_PIX_WD-1:0] ur_dat_i,
  input  logic [`DAT_PIX_WD-1:0] bl_dat_i,
  input  logic [`DAT_PIX_WD-1:0] br_dat_i,
  input  logic                   dsc_vld_i,
  input  logic [`WGT_WD-1:0]     wx_i,
  input  logic [`WGT_WD-1:0]     wy_i,
  input  logic [3:0]             msk_i,
  output logic                   vld_o,
  output logic [`DAT_PIX_WD-1:0] dat_o,
  output logic                   ovf_o
);
  logic [3:0]            c_vld, c_pop, c_empty, c_full, c_ovf;
  logic [3:0][DAT_W-1:0] c_din, c_head;
  logic                  d_empty, d_full, d_ovf, join_fire;
  dsc_t                  d_din, hd;
  logic [DSC_W-1:0]      d_head;
  logic                  unused_full;

  assign c_vld = {ul_vld_i, ur_vld_i, bl_vld_i, br_vld_i};
  assign c_din = {ul_dat_i, ur_dat_i, bl_dat_i, br_dat_i};

  for (genvar g = 0; g < 4; g++) begin : g_crn
    che_itp_fifo #(.WD(DAT_W)) u_crn_fifo (
      .clk(clk), .rst(rst),
      .s_tvalid_i(c_vld[g]), .s_tdata_i(c_din[g]),
      .m_tready_i(c_pop[g]), .m_tdata_o(c_head[g]),
      .full_o(c_full[g]), .empty_o(c_empty[g]), .ovf_o(c_ovf[g])
    );
  end

  assign d_din = '{wx: clamp_wgt(wx_i), wy: clamp_wgt(wy_i), msk: msk_i};

  che_itp_fifo #(.WD(DSC_W)) u_dsc_fifo (
    .clk(clk), .rst(rst),
    .s_tvalid_i(dsc_vld_i), .s_tdata_i(d_din),
    .m_tready_i(join_fire), .m_tdata_o(d_head),
    .full_o(d_full), .empty_o(d_empty), .ovf_o(d_ovf)
  );

  assign unused_full = &{1'b0, c_full, d_full};
  assign hd          = d_head;
  assign join_fire   = ~d_empty & ~(|(hd.msk & c_empty));
  assign c_pop       = {4{join_fire}} & hd.msk;
  assign ovf_o       = |c_ovf | d_ovf;

  logic [DAT_W-1:0] top_a, top_b, bot_a, bot_b;
  logic [WGT_W-1:0] iwx, iwy;
  logic [ROW_W-1:0] top_raw, bot_raw, top_d, bot_d, top_q, bot_q;
  logic [WGT_W-1:0] wy_q;
  logic [SUM_W-1:0] sum_d, sum_q, rnd;
  logic [DAT_W-1:0] dat_d, dat_q;
  logic             s1_vld_q, s2_vld_q, vld_q;

  // A missing corner takes its row partner; a missing row takes the other row.
  always_comb begin
    top_a   = hd.msk[UL_B] ? c_head[UL_B] : c_head[UR_B];
    top_b   = hd.msk[UR_B] ? c_head[UR_B] : c_head[UL_B];
    bot_a   = hd.msk[BL_B] ? c_head[BL_B] : c_head[BR_B];
    bot_b   = hd.msk[BR_B] ? c_head[BR_B] : c_head[BL_B];
    iwx     = WGT_W'(`WGT_ONE) - hd.wx;
    top_raw = ROW_W'(top_a) * ROW_W'(iwx) + ROW_W'(top_b) * ROW_W'(hd.wx);
    bot_raw = ROW_W'(bot_a) * ROW_W'(iwx) + ROW_W'(bot_b) * ROW_W'(hd.wx);
    top_d   = '0;
    bot_d   = '0;
    if (|hd.msk[UL_B:UR_B]) top_d = top_raw;
    else if (|hd.msk[BL_B:BR_B]) top_d = bot_raw;
    if (|hd.msk[BL_B:BR_B]) bot_d = bot_raw;
    else if (|hd.msk[UL_B:UR_B]) bot_d = top_raw;
  end

  always_comb begin
    iwy   = WGT_W'(`WGT_ONE) - wy_q;
    sum_d = SUM_W'(top_q) * SUM_W'(iwy) + SUM_W'(bot_q) * SUM_W'(wy_q);
    rnd   = sum_q + SUM_W'(1 << (`ITP_SHF - 1));
    dat_d = rnd[`ITP_SHF +: DAT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      top_q    <= '0;
      bot_q    <= '0;
      wy_q     <= '0;
      s2_vld_q <= 1'b0;
      sum_q    <= '0;
      vld_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      s1_vld_q <= join_fire;
      if (join_fire) begin
        top_q <= top_d;
        bot_q <= bot_d;
        wy_q  <= hd.wy;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) sum_q <= sum_d;
      vld_q <= s2_vld_q;
      if (s2_vld_q) dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
endmodule

// File: tb/tb_che_bilinear_itp.sv
// tb/tb_che_bilinear_itp.sv - directed self-checking bench for che_bilinear_itp
module tb_che_bilinear_itp;
  logic       clk = 1'b0;
  logic       rst;
  logic       ul_vld, ur_vld, bl_vld, br_vld, dsc_vld;
  logic [7:0] ul_dat, ur_dat, bl_dat, br_dat;
  logic [6:0] wx, wy;
  logic [3:0] msk;
  logic       vld_o, ovf_o;
  logic [7:0] dat_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int obs_d[$];
  int obs_c[$];
  int base;

  always #5 clk = ~clk;

  che_bilinear_itp dut (
    .clk(clk), .rst(rst),
    .ul_vld_i(ul_vld), .ur_vld_i(ur_vld), .bl_vld_i(bl_vld), .br_vld_i(br_vld),
    .ul_dat_i(ul_dat), .ur_dat_i(ur_dat), .bl_dat_i(bl_dat), .br_dat_i(br_dat),
    .dsc_vld_i(dsc_vld), .wx_i(wx), .wy_i(wy), .msk_i(msk),
    .vld_o(vld_o), .dat_o(dat_o), .ovf_o(ovf_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld_o === 1'b1) begin
      obs_d.push_back(int'(dat_o));
      obs_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {ul_vld, ur_vld, bl_vld, br_vld, dsc_vld} = '0;
  endtask

  task automatic offer(input logic [3:0] cv, input logic dv,
                       input int a, input int b, input int c, input int d,
                       input int x, input int y, input logic [3:0] m);
    {ul_vld, ur_vld, bl_vld, br_vld} = cv;
    dsc_vld = dv;
    ul_dat = 8'(a); ur_dat = 8'(b); bl_dat = 8'(c); br_dat = 8'(d);
    wx = 7'(x); wy = 7'(y); msk = m;
  endtask

  function automatic int ref_itp(input int a, input int b, input int c, input int d,
                                 input int x, input int y);
    int t, u;
    t = a * (64 - x) + b * x;
    u = c * (64 - x) + d * x;
    return (t * (64 - y) + u * y + 2048) / 4096;
  endfunction

  task automatic single(input string tag, input int exp);
    step(); idle();
    step(); chk({tag, "_lat1"}, int'(vld_o), 0);
    step(); chk({tag, "_lat2"}, int'(vld_o), 0);
    step(); chk({tag, "_vld"}, int'(vld_o), 1);
    chk({tag, "_dat"}, int'(dat_o), exp);
    step(); chk({tag, "_pulse"}, int'(vld_o), 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    offer(4'b0000, 1'b0, 0, 0, 0, 0, 0, 0, 4'b0000);
    repeat (3) step();
    chk("rst_vld", int'(vld_o), 0);
    chk("rst_dat", int'(dat_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    rst = 1'b0;
    step();

    offer(4'b1111, 1'b1, 0, 255, 0, 255, 32, 0, 4'b1111);
    single("full_mask", 128);

    offer(4'b1110, 1'b1, 80, 80, 80, 80, 10, 20, 4'b1111);
    step(); idle();
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) br_vld = 1'b1;
      step();
      br_vld = 1'b0;
      chk($sformatf("skew_t%0d", k), int'(vld_o), 0);
    end
    step(); chk("skew_vld", int'(vld_o), 1);
    chk("skew_dat", int'(dat_o), 80);
    step(); chk("skew_pulse", int'(vld_o), 0);

    offer(4'b1010, 1'b1, 100, 0, 200, 0, 50, 16, 4'b1010);
    single("partial", 125);

    offer(4'b0000, 1'b1, 0, 0, 0, 0, 20, 30, 4'b0000);
    single("mask_zero", 0);

    offer(4'b0100, 1'b1, 0, 60, 0, 0, 17, 40, 4'b0100);
    single("one_corner", 60);

    offer(4'b1111, 1'b1, 10, 200, 30, 90, 127, 127, 4'b1111);
    single("clamp", 90);

    base = obs_d.size();
    for (int i = 0; i < 20; i++) begin
      offer(4'b1111, 1'b1, i * 12, 255 - i * 12, i * 7, 200 - i * 5, i * 3, 64 - i * 3, 4'b1111);
      step();
    end
    idle();
    repeat (6) step();
    chk("b2b_count", obs_d.size() - base, 20);
    if (obs_d.size() - base == 20) begin
      for (int i = 0; i < 20; i++)
        chk($sformatf("b2b_dat%0d", i), obs_d[base + i],
            ref_itp(i * 12, 255 - i * 12, i * 7, 200 - i * 5, i * 3, 64 - i * 3));
      chk("b2b_span", obs_c[base + 19] - obs_c[base], 19);
    end

    base = obs_d.size();
    for (int i = 1; i <= 5; i++) begin
      offer(4'b0000, 1'b1, 0, 0, 0, 0, 0, 0, 4'b1111);
      step();
      if (i == 4) chk("ovf_at4", int'(ovf_o), 0);
      if (i == 5) chk("ovf_at5", int'(ovf_o), 1);
    end
    idle();
    repeat (6) step();
    chk("ovf_no_vld", obs_d.size() - base, 0);
    for (int i = 1; i <= 4; i++) begin
      offer(4'b1111, 1'b0, 10 * i, 1, 2, 3, 0, 0, 4'b1111);
      step();
    end
    idle();
    repeat (6) step();
    chk("ovf_kept4", obs_d.size() - base, 4);
    if (obs_d.size() - base == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("ovf_dat%0d", i), obs_d[base + i], 10 * (i + 1));
    offer(4'b1111, 1'b0, 99, 99, 99, 99, 0, 0, 4'b1111);
    step(); idle();
    repeat (6) step();
    chk("ovf_no5th", obs_d.size() - base, 4);
    chk("ovf_sticky", int'(ovf_o), 1);

    base = obs_d.size();
    offer(4'b1111, 1'b1, 50, 50, 50, 50, 0, 0, 4'b1111);
    step();
    offer(4'b0000, 1'b1, 0, 0, 0, 0, 64, 64, 4'b1111);
    step(); idle();
    rst = 1'b1;
    offer(4'b1000, 1'b1, 77, 0, 0, 0, 5, 5, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rst_mid_vld%0d", k), int'(vld_o), 0);
    end
    chk("rst_mid_ovf", int'(ovf_o), 0);
    idle();
    rst = 1'b0;
    step();
    chk("rst_mid_none", obs_d.size() - base, 0);
    offer(4'b1111, 1'b1, 33, 33, 33, 33, 0, 0, 4'b1111);
    single("post_rst", 33);
    repeat (4) step();
    chk("post_rst_count", obs_d.size() - base, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
